// File: rtl/apb3_cmd_master_if.sv
// Bundle of the command stream, response stream and APB3 bus seen by
// apb3_cmd_master. The master modport is the initiator's view; the slave
// modport is the view of whatever sits around it (user logic plus completer).
interface apb3_cmd_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_error;
  logic [7:0]            err_count;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERROR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PREADY, PRDATA, PSLVERROR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_error, err_count,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PREADY, PRDATA, PSLVERROR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, err_count,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/apb3_cmd_master.sv
// APB3 initiator: turns one accepted command into a single SETUP/ACCESS
// transfer and returns PRDATA/PSLVERROR on a valid/ready response stream.
// Optional feature macro: APB3_MASTER_TIMEOUT_EN enables an ACCESS-phase
// wait limit of TIMEOUT_CYCLES; without it ACCESS waits for PREADY forever.
module apb3_cmd_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                io_systemClk,
  input logic                io_systemReset,
  apb3_cmd_master_if.master  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  logic [1:0]            state_q,     state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] timer_q, timer_d;
`endif

  // Next-state and next-output logic for the IDLE/SETUP/ACCESS/RESP sequence
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    err_count_d = err_count_q;
    paddr_d     = paddr_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
`ifdef APB3_MASTER_TIMEOUT_EN
    timer_d     = timer_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB3_MASTER_TIMEOUT_EN
        timer_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_error_d = bus.PSLVERROR;
          if (bus.PSLVERROR && err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
`ifdef APB3_MASTER_TIMEOUT_EN
        else begin
          timer_d = timer_q + 16'd1;
          if (timer_d == TIMEOUT_LIMIT) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
`endif
      end
      default: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State and registered outputs; reset abandons any transfer or pending response
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      err_count_q <= '0;
      paddr_q     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      err_count_q <= err_count_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

`ifdef APB3_MASTER_TIMEOUT_EN
  // ACCESS wait counter, cleared while in SETUP
  always_ff @(posedge io_systemClk) begin
    if (io_systemReset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.err_count = err_count_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Directed bench for apb3_cmd_master. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge. The timeout scenario is only
// built when APB3_MASTER_TIMEOUT_EN is defined (with TIMEOUT_CYCLES=8).
module tb_apb3_cmd_master;

`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  apb3_cmd_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  apb3_cmd_master #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .io_systemClk  (clk),
    .io_systemReset(rst),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait transfer used to build up error counts
  task automatic run_transfer(input logic wr, input logic [15:0] addr,
                              input logic [31:0] rdata, input logic err);
    int budget;
    budget = 0;
    while (bus.cmd_ready !== 1'b1 && budget < 20) begin
      step();
      budget++;
    end
    n_compared++;
    if (bus.cmd_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL idle_wait: cmd_ready got %0b want 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_wdata = 32'h0; bus.PREADY = 1'b1; bus.PRDATA = rdata;
    bus.PSLVERROR = err; bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step(); step(); step();
    bus.PSLVERROR = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_compared++; if (bus.cmd_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_cmd_ready: got %0b want 0", bus.cmd_ready); end
    n_compared++; if (bus.rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_rsp_valid: got %0b want 0", bus.rsp_valid); end
    n_compared++; if (bus.rsp_rdata !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_rsp_rdata: got %0h want 0", bus.rsp_rdata); end
    n_compared++; if (bus.rsp_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rst_rsp_error: got %0b want 0", bus.rsp_error); end
    n_compared++; if (bus.err_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL rst_err_count: got %0d want 0", bus.err_count); end
    n_compared++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL rst_ctrl: got %b want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    n_compared++; if (bus.PADDR !== 16'h0 || bus.PWDATA !== 32'h0) begin n_mismatched++; $display("[TB] FAIL rst_addr_data: got %0h/%0h want 0/0", bus.PADDR, bus.PWDATA); end
    rst = 1'b0;
    step();
    n_compared++; if (bus.cmd_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rst_release_ready: got %0b want 1", bus.cmd_ready); end
  endtask

  task automatic test_zero_wait_write();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 16'h0010;
    bus.cmd_wdata = 32'hA5A5_0001; bus.PREADY = 1'b1; bus.PRDATA = 32'h5555_AAAA;
    bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    n_compared++; if ({bus.PSEL, bus.PENABLE} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL t1_setup: psel/penable got %b want 10", {bus.PSEL, bus.PENABLE}); end
    n_compared++; if (bus.cmd_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL t1_ready_low: got %0b want 0", bus.cmd_ready); end
    n_compared++; if (bus.PADDR !== 16'h0010 || bus.PWDATA !== 32'hA5A5_0001 || bus.PWRITE !== 1'b1) begin n_mismatched++; $display("[TB] FAIL t1_latch: got %0h/%0h/%0b want 10/a5a50001/1", bus.PADDR, bus.PWDATA, bus.PWRITE); end
    step();
    n_compared++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL t1_access: psel/penable/rsp_valid got %b want 110", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    step();
    n_compared++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b001) begin n_mismatched++; $display("[TB] FAIL t1_resp: psel/penable/rsp_valid got %b want 001", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    n_compared++; if (bus.rsp_rdata !== 32'h0 || bus.rsp_error !== 1'b0) begin n_mismatched++; $display("[TB] FAIL t1_rsp_data: got %0h/%0b want 0/0", bus.rsp_rdata, bus.rsp_error); end
    step();
    n_compared++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL t1_back_idle: rsp_valid/cmd_ready got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
    n_compared++; if (bus.PADDR !== 16'h0010) begin n_mismatched++; $display("[TB] FAIL t1_addr_hold: got %0h want 10", bus.PADDR); end
  endtask

  task automatic test_read_wait_states();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0044;
    bus.cmd_wdata = 32'h0; bus.PREADY = 1'b0; bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      n_compared++; if ({bus.PSEL, bus.PENABLE} !== 2'b11 || bus.PADDR !== 16'h0044 || bus.rsp_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL t2_access_%0d: psel/penable %b addr %0h rsp_valid %0b want 11 44 0", i, {bus.PSEL, bus.PENABLE}, bus.PADDR, bus.rsp_valid); end
      if (i < 3) begin
        bus.PREADY = 1'b0; bus.PRDATA = 32'hDEAD_BEEF; bus.PSLVERROR = 1'b1;
      end else begin
        bus.PREADY = 1'b1; bus.PRDATA = 32'h1234_5678; bus.PSLVERROR = 1'b0;
      end
      step();
    end
    n_compared++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b001) begin n_mismatched++; $display("[TB] FAIL t2_resp: psel/penable/rsp_valid got %b want 001", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    n_compared++; if (bus.rsp_rdata !== 32'h1234_5678) begin n_mismatched++; $display("[TB] FAIL t2_rdata: got %0h want 12345678", bus.rsp_rdata); end
    n_compared++; if (bus.rsp_error !== 1'b0 || bus.err_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL t2_no_error: got %0b/%0d want 0/0", bus.rsp_error, bus.err_count); end
    step();
  endtask

  task automatic test_slave_error();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0050;
    bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFE_0001; bus.PSLVERROR = 1'b1;
    bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step(); step();
    n_compared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1) begin n_mismatched++; $display("[TB] FAIL t3_error: rsp_valid/rsp_error got %0b/%0b want 1/1", bus.rsp_valid, bus.rsp_error); end
    n_compared++; if (bus.rsp_rdata !== 32'hCAFE_0001) begin n_mismatched++; $display("[TB] FAIL t3_rdata: got %0h want cafe0001", bus.rsp_rdata); end
    n_compared++; if (bus.err_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL t3_count_1: got %0d want 1", bus.err_count); end
    step();
    bus.PSLVERROR = 1'b0;
    n_compared++; if (bus.err_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL t3_count_once: got %0d want 1", bus.err_count); end
    for (int i = 0; i < 253; i++) run_transfer(1'b0, 16'h0100, 32'h0, 1'b1);
    n_compared++; if (bus.err_count !== 8'd254) begin n_mismatched++; $display("[TB] FAIL t3_count_254: got %0d want 254", bus.err_count); end
    run_transfer(1'b0, 16'h0104, 32'h0, 1'b1);
    n_compared++; if (bus.err_count !== 8'd255) begin n_mismatched++; $display("[TB] FAIL t3_count_255: got %0d want 255", bus.err_count); end
    for (int i = 0; i < 46; i++) run_transfer(1'b1, 16'h0108, 32'h0, 1'b1);
    n_compared++; if (bus.err_count !== 8'd255) begin n_mismatched++; $display("[TB] FAIL t3_saturate: got %0d want 255", bus.err_count); end
  endtask

  task automatic test_backpressure();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0040;
    bus.PREADY = 1'b1; bus.PRDATA = 32'h0BAD_F00D; bus.rsp_ready = 1'b0;
    step(); step(); step();
    bus.PRDATA = 32'h7777_7777;
    for (int i = 0; i < 5; i++) begin
      n_compared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0BAD_F00D) begin n_mismatched++; $display("[TB] FAIL t4_hold_%0d: rsp_valid %0b rdata %0h want 1 badf00d", i, bus.rsp_valid, bus.rsp_rdata); end
      n_compared++; if (bus.cmd_ready !== 1'b0 || bus.PSEL !== 1'b0 || bus.PADDR !== 16'h0040) begin n_mismatched++; $display("[TB] FAIL t4_blocked_%0d: cmd_ready %0b psel %0b addr %0h want 0 0 40", i, bus.cmd_ready, bus.PSEL, bus.PADDR); end
      step();
    end
    bus.rsp_ready = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 16'h0030; bus.cmd_wdata = 32'h0000_0030;
    n_compared++; if (bus.cmd_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL t4_ready_still_low: got %0b want 0", bus.cmd_ready); end
    step();
    n_compared++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL t4_release: rsp_valid/cmd_ready got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
    step();
    bus.cmd_valid = 1'b0;
    n_compared++; if (bus.PSEL !== 1'b1 || bus.PADDR !== 16'h0030 || bus.PWRITE !== 1'b1) begin n_mismatched++; $display("[TB] FAIL t4_next_cmd: psel %0b addr %0h pwrite %0b want 1 30 1", bus.PSEL, bus.PADDR, bus.PWRITE); end
    step(); step(); step();
  endtask

  task automatic test_reset_in_access();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0060;
    bus.PREADY = 1'b0; bus.rsp_ready = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    step();
    n_compared++; if (bus.PENABLE !== 1'b1) begin n_mismatched++; $display("[TB] FAIL t5_in_access: penable got %0b want 1", bus.PENABLE); end
    rst = 1'b1;
    step();
    rst = 1'b0; bus.PREADY = 1'b1;
    n_compared++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b000) begin n_mismatched++; $display("[TB] FAIL t5_abort: psel/penable/rsp_valid got %b want 000", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    n_compared++; if (bus.err_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL t5_err_clear: got %0d want 0", bus.err_count); end
    step();
    n_compared++; if ({bus.cmd_ready, bus.rsp_valid} !== 2'b10) begin n_mismatched++; $display("[TB] FAIL t5_after_release: cmd_ready/rsp_valid got %b want 10", {bus.cmd_ready, bus.rsp_valid}); end
    step();
    n_compared++; if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin n_mismatched++; $display("[TB] FAIL t5_no_rsp: rsp_valid/psel got %0b/%0b want 0/0", bus.rsp_valid, bus.PSEL); end
  endtask

`ifdef APB3_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0070;
    bus.PREADY = 1'b0; bus.PRDATA = 32'h1111_2222; bus.rsp_ready = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      n_compared++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin n_mismatched++; $display("[TB] FAIL t6_waiting_%0d: psel/penable/rsp_valid got %b want 110", i, {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
      step();
    end
    n_compared++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b001) begin n_mismatched++; $display("[TB] FAIL t6_abort: psel/penable/rsp_valid got %b want 001", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    n_compared++; if (bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.err_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL t6_rsp: error %0b rdata %0h count %0d want 1 0 1", bus.rsp_error, bus.rsp_rdata, bus.err_count); end
    bus.PREADY = 1'b1; bus.PSLVERROR = 1'b0;
    step(); step();
    n_compared++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.err_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL t6_late_pready: valid %0b error %0b rdata %0h count %0d want 1 1 0 1", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata, bus.err_count); end
    bus.rsp_ready = 1'b1;
    step();
    n_compared++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin n_mismatched++; $display("[TB] FAIL t6_back_idle: rsp_valid/cmd_ready got %b want 01", {bus.rsp_valid, bus.cmd_ready}); end
  endtask
`endif

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 16'h0;
    bus.cmd_wdata = 32'h0; bus.rsp_ready = 1'b1; bus.PREADY = 1'b1;
    bus.PRDATA = 32'h0; bus.PSLVERROR = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_read_wait_states();
    test_slave_error();
    test_backpressure();
    test_reset_in_access();
`ifdef APB3_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
